// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Arbiter FSM states, latched-transaction record and streak counter width.
package data_path_muxs_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IBUS = 2'b01,
    DBUS = 2'b10,
    GAP  = 2'b11
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_IFETCH = 2'b01,
    OP_DREAD  = 2'b10,
    OP_DWRITE = 2'b11
  } txn_op_t;

  typedef struct packed {
    txn_op_t              op;
    cpu_types_pkg::word_t addr;
    cpu_types_pkg::word_t store;
  } txn_t;

endpackage

// File: rtl/arb_priority.sv
// Combinational grant decision: data wins unless the fairness streak has
// reached D_STREAK while an instruction fetch is waiting.
module arb_priority
  import data_path_muxs_pkg::*;
#(
  parameter int D_STREAK = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  input  logic                fair_en,
  output logic                grant_i,
  output logic                grant_d
);

  logic fair_turn;

  assign fair_turn = fair_en && i_req && (streak == STREAK_W'(D_STREAK));
  assign grant_d   = d_req && !fair_turn;
  assign grant_i   = i_req && !grant_d;

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between ifetch and data requesters.
// Optional round-robin-ish fairness enabled by defining MEMORY_ARBITER_FAIRNESS_EN.
module memory_arbiter
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter int D_STREAK = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arb_state_t          state_reg, state_next;
  txn_t                txn_reg;
  logic                abandon_reg;
  logic                d_req, grant_i, grant_d;
  logic                done, live_req, abandoned;
  logic [STREAK_W-1:0] streak;
  logic                fair_en;

  assign d_req     = dREN | dWEN;
  assign done      = (ramstate == ACCESS) || (ramstate == ERROR);
  assign live_req  = (state_reg == IBUS) ? iREN : d_req;
  // A requester that dropped at any point during its bus phase gets no completion.
  assign abandoned = abandon_reg || !live_req;

  arb_priority #(
    .D_STREAK (D_STREAK)
  ) u_arb_priority (
    .i_req   (iREN),
    .d_req   (d_req),
    .streak  (streak),
    .fair_en (fair_en),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  logic [STREAK_W-1:0] streak_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (grant_i) begin
        streak_reg <= '0;
      end else if (grant_d && iREN && (streak_reg != STREAK_W'(D_STREAK))) begin
        streak_reg <= streak_reg + 1'b1;
      end
    end
  end

  assign streak  = streak_reg;
  assign fair_en = 1'b1;
`else
  assign streak  = '0;
  assign fair_en = 1'b0;
`endif

  // State and transaction registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      txn_reg     <= '0;
      abandon_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          abandon_reg <= 1'b0;
          if (grant_d) begin
            txn_reg <= '{op: (dWEN ? OP_DWRITE : OP_DREAD), addr: daddr, store: dstore};
          end else if (grant_i) begin
            txn_reg <= '{op: OP_IFETCH, addr: iaddr, store: '0};
          end
        end
        IBUS, DBUS: begin
          if (!live_req) abandon_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d)      state_next = DBUS;
        else if (grant_i) state_next = IBUS;
      end
      IBUS, DBUS: begin
        if (done) state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;
    if (state_reg == IBUS || state_reg == DBUS) begin
      ramREN   = (txn_reg.op != OP_DWRITE);
      ramWEN   = (txn_reg.op == OP_DWRITE);
      ramaddr  = txn_reg.addr;
      ramstore = txn_reg.store;
      if (done) begin
        err = (ramstate == ERROR);
        if (!abandoned) begin
          if (state_reg == IBUS) begin
            iwait = 1'b0;
            iload = ramload;
          end else begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a completion scoreboard.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic        is_d;
    logic [31:0] load;
    logic        err;
  } exp_t;

  logic      CLK = 1'b0;
  logic      RST = 1'b1;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0;
  logic      iwait, dwait, ramREN, ramWEN, err;
  word_t     iload, dload, ramaddr, ramstore;
  word_t     ramload = '0;
  ramstate_t ramstate = FREE;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  memory_arbiter #(.D_STREAK(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard whenever a wait is low in the sampled cycle.
  task automatic watch();
    exp_t e;
    if (iwait === 1'b0 || dwait === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", {30'b0, iwait, dwait}, 32'h3);
      end else begin
        e = exp_q.pop_front();
        chk1("sb_requester", (dwait === 1'b0), e.is_d);
        chk("sb_load", e.is_d ? dload : iload, e.load);
        chk1("sb_err", err, e.err);
        $display("txn %s load=%h err=%b", e.is_d ? "data " : "ifetch", e.is_d ? dload : iload, err);
      end
    end else begin
      chk1("err_quiet", err, 1'b0);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input ramstate_t rs, input logic [31:0] rl);
    ramstate = rs;
    ramload  = rl;
    #2;
    watch();
  endtask

  task automatic push(input logic is_d, input logic [31:0] load, input logic e);
    exp_t x;
    x.is_d = is_d;
    x.load = load;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_d;
    logic [31:0] exp_a;

    // Reset state, with a nonzero ramload to prove loads are gated
    RST = 1'b1;
    next(); next();
    step(FREE, 32'h1234_5678);
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_dwait", dwait, 1'b1);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk1("rst_err", err, 1'b0);

    // Single ifetch with two BUSY cycles
    RST = 1'b0; iREN = 1'b1; iaddr = 32'h0000_0040;
    step(FREE, 32'h0);
    chk1("if_idle_ramREN", ramREN, 1'b0);
    next();
    for (int c = 0; c < 2; c++) begin
      step(BUSY, 32'h0);
      chk1("if_busy_ramREN", ramREN, 1'b1);
      chk("if_busy_ramaddr", ramaddr, 32'h40);
      chk1("if_busy_iwait", iwait, 1'b1);
      next();
    end
    push(1'b0, 32'h2108_0001, 1'b0);
    step(ACCESS, 32'h2108_0001);
    chk1("if_acc_ramREN", ramREN, 1'b1);
    chk("if_acc_ramaddr", ramaddr, 32'h40);
    chk1("if_acc_iwait", iwait, 1'b0);
    next();
    step(FREE, 32'h0);
    chk1("if_gap_ramREN", ramREN, 1'b0);
    chk1("if_gap_iwait", iwait, 1'b1);
    iREN = 1'b0;
    next();
    step(FREE, 32'h0);
    chk1("if_idle2_ramREN", ramREN, 1'b0);
    next();

    // Conflict: data write wins, ifetch follows after GAP
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    step(FREE, 32'h0);
    chk1("cf_idle_ramWEN", ramWEN, 1'b0);
    next();
    push(1'b1, 32'h5555_5555, 1'b0);
    step(ACCESS, 32'h5555_5555);
    chk1("cf_d_ramWEN", ramWEN, 1'b1);
    chk1("cf_d_ramREN", ramREN, 1'b0);
    chk("cf_d_ramaddr", ramaddr, 32'h100);
    chk("cf_d_ramstore", ramstore, 32'hDEAD_BEEF);
    chk1("cf_d_iwait", iwait, 1'b1);
    dWEN = 1'b0;
    next();
    step(FREE, 32'h0);
    chk1("cf_gap_ramWEN", ramWEN, 1'b0);
    chk("cf_gap_ramaddr", ramaddr, 32'h0);
    next();
    step(FREE, 32'h0);
    chk1("cf_idle_ramREN", ramREN, 1'b0);
    next();
    push(1'b0, 32'h0000_0077, 1'b0);
    step(ACCESS, 32'h0000_0077);
    chk1("cf_i_ramREN", ramREN, 1'b1);
    chk("cf_i_ramaddr", ramaddr, 32'h80);
    chk("cf_i_ramstore", ramstore, 32'h0);
    iREN = 1'b0;
    next();
    step(FREE, 32'h0);
    next();

    // Abandon: dREN dropped while RAM busy, live address changes ignored
    dREN = 1'b1; daddr = 32'h200;
    step(FREE, 32'h0);
    next();
    step(BUSY, 32'h0);
    chk1("ab_busy_ramREN", ramREN, 1'b1);
    chk("ab_busy_ramaddr", ramaddr, 32'h200);
    dREN = 1'b0; daddr = 32'h999;
    next();
    step(BUSY, 32'h0);
    chk1("ab_busy2_ramREN", ramREN, 1'b1);
    chk("ab_busy2_ramaddr", ramaddr, 32'h200);
    chk1("ab_busy2_dwait", dwait, 1'b1);
    next();
    step(ACCESS, 32'h0000_0ABC);
    chk1("ab_acc_ramREN", ramREN, 1'b1);
    chk1("ab_acc_dwait", dwait, 1'b1);
    next();
    step(FREE, 32'h0);
    chk1("ab_gap_ramREN", ramREN, 1'b0);
    next();
    step(FREE, 32'h0);
    chk1("ab_idle_ramREN", ramREN, 1'b0);
    next();
    step(FREE, 32'h0);
    chk1("ab_idle2_ramREN", ramREN, 1'b0);

    // Error completion on an ifetch
    iREN = 1'b1; iaddr = 32'h300;
    step(FREE, 32'h0);
    next();
    push(1'b0, 32'h0000_EEEE, 1'b1);
    step(ERROR, 32'h0000_EEEE);
    chk1("er_bus_iwait", iwait, 1'b0);
    chk1("er_bus_err", err, 1'b1);
    iREN = 1'b0;
    next();
    step(FREE, 32'h0);
    chk1("er_gap_err", err, 1'b0);
    chk1("er_gap_iwait", iwait, 1'b1);
    next();
    step(FREE, 32'h0);
    chk1("er_idle_err", err, 1'b0);

    // Reset in the middle of a data write
    dWEN = 1'b1; daddr = 32'h400; dstore = 32'h11;
    step(FREE, 32'h0);
    next();
    step(BUSY, 32'h0);
    chk1("rm_bus_ramWEN", ramWEN, 1'b1);
    RST = 1'b1;
    next();
    step(BUSY, 32'h0);
    chk1("rm_rst_ramWEN", ramWEN, 1'b0);
    chk1("rm_rst_ramREN", ramREN, 1'b0);
    chk1("rm_rst_dwait", dwait, 1'b1);
    chk1("rm_rst_iwait", iwait, 1'b1);
    chk("rm_rst_ramaddr", ramaddr, 32'h0);
    next();
    RST = 1'b0;
    step(FREE, 32'h0);
    chk1("rm_idle_ramWEN", ramWEN, 1'b0);
    next();
    push(1'b1, 32'h0000_0042, 1'b0);
    step(ACCESS, 32'h0000_0042);
    chk1("rm_regrant_ramWEN", ramWEN, 1'b1);
    chk("rm_regrant_ramaddr", ramaddr, 32'h400);
    dWEN = 1'b0;
    next();
    step(FREE, 32'h0);
    next();

    // Fairness: both requesters held continuously
    dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h600;
    for (int k = 0; k < 10; k++) begin
`ifdef MEMORY_ARBITER_FAIRNESS_EN
      exp_d = ((k % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      exp_a = exp_d ? 32'h500 : 32'h600;
      step(FREE, 32'h0);
      chk1("fa_idle_ramREN", ramREN, 1'b0);
      next();
      push(exp_d, 32'h1000 + 32'(k), 1'b0);
      step(ACCESS, 32'h1000 + 32'(k));
      chk1("fa_bus_ramREN", ramREN, 1'b1);
      chk("fa_bus_ramaddr", ramaddr, exp_a);
      next();
      step(FREE, 32'h0);
      chk1("fa_gap_ramREN", ramREN, 1'b0);
      next();
    end
    dREN = 1'b0; iREN = 1'b0;
    step(FREE, 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter sharing the single-port RAM between the instruction-fetch and data-memory requesters of the five-stage pipeline. It sits between the cache/pipeline request side and the RAM model. It latches one request per transaction and holds it on the RAM bus until the RAM reports completion. It returns per-requester wait/load signals, which the hazard unit consumes as ihit/dhit.

## Interface
- D_STREAK, 4: max consecutive data grants while an ifetch is pending (fairness mode only); 1..15
- CLK  in  1  pipeline clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32 (word_t)  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN and dWEN never both high
- daddr  in  32  data address
- dstore  in  32  data write value
- iwait  out  1  low for exactly the completion cycle of an instruction read
- dwait  out  1  low for exactly the completion cycle of a data access
- iload  out  32  ramload, valid while iwait low
- dload  out  32  ramload, valid while dwait low
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr, ramstore  out  32 each  latched transaction address/data
- ramload  in  32  RAM read data
- ramstate  in  2 (ramstate_t)  FREE, BUSY, ACCESS, ERROR
- err  out  1  one-cycle pulse when a transaction ends with ERROR

## Operation
- FSM states: IDLE, IBUS, DBUS, GAP.
- IDLE: arbitrate. A data request (dREN|dWEN) wins over iREN. On a grant, latch addr, store data and op into txn registers, then move to DBUS or IBUS.
- IBUS/DBUS: drive ramREN/ramWEN, ramaddr and ramstore from the txn registers only; live inputs are ignored.
- Completion: ramstate==ACCESS drives the granted wait low combinationally in that cycle, with load=ramload; next state GAP.
- ERROR: treated as completion. Wait goes low, err=1, next state GAP.
- FREE/BUSY: stay in the state.
- GAP: RAM strobes low, both waits high, then return to IDLE. This prevents re-granting a request that the requester drops only after seeing wait low.
- Abandon: if the granted request deasserts before completion (pipeline flush), the txn continues to completion. Wait stays high at completion and the result is discarded.
- Waits: high whenever the requester is not in its completion cycle, including in IDLE.
- Outputs while not granted: RAM strobes 0, ramaddr/ramstore 0.
- Reset: state IDLE, txn registers 0, streak counter 0. Every output reads 0 except iwait=dwait=1.
- Reset mid-transaction: the txn is abandoned. Strobes drop in the cycle after RST is sampled high.

## Timing
- Grant latency: request sampled in IDLE, RAM strobes asserted the next cycle.
- Minimum access: 3 cycles of occupancy (IDLE, BUS with ACCESS, GAP). Back-to-back throughput is one transaction per 3 cycles plus RAM BUSY cycles.
- Simultaneous iREN and dREN in IDLE: data is granted; the ifetch is granted after the following GAP if still requested.
- RAM strobes never change during a BUS state.

## Configuration
- MEMORY_ARBITER_FAIRNESS_EN defined: a 4-bit streak counter increments on each data grant made while iREN is high, and clears on any instruction grant.
  - When streak==D_STREAK and iREN is high in IDLE, the instruction is granted even if a data request is present.
  - The counter saturates at D_STREAK.
- Not defined: strict data priority, no counter, and D_STREAK is unused.

## Structure
- cpu_types_pkg: word_t, ramstate_t.
- data_path_muxs_pkg: arb_state_t (IDLE, IBUS, DBUS, GAP) and a txn_t struct holding op, addr and store.
- One sub-module is natural: arb_priority, a combinational grant decision taking requests, streak and enable, and producing grant_i/grant_d.
- The FSM and txn registers stay in memory_arbiter.

## Test plan
- Single ifetch: iREN=1, iaddr=0x0000_0040; RAM BUSY 2 cycles then ACCESS with ramload=0x2108_0001. Required: ramREN=1 and ramaddr=0x40 for 3 cycles; iwait low only in the ACCESS cycle; iload=0x2108_0001; GAP follows.
- Conflict: iREN and dWEN both high in IDLE, daddr=0x100, dstore=0xDEAD_BEEF. Required: ramWEN with ramaddr=0x100 and ramstore=0xDEADBEEF first; ifetch begins 1 cycle after GAP.
- Abandon: dREN deasserted one cycle after grant while RAM is still BUSY. Required: ramREN held until ACCESS, dwait stays high throughout, then GAP→IDLE.
- Error: ramstate=ERROR during IBUS. Required: iwait=0 and err=1 for exactly 1 cycle, then GAP.
- Reset mid-transaction: RST=1 during DBUS. Required: the next cycle has ramWEN=0, ramREN=0, waits=1, state IDLE; the interrupted request is re-arbitrated only after RST is deasserted.
- Fairness (macro defined, D_STREAK=4): dREN and iREN held continuously. Required: 4 data grants, then 1 instruction grant, then data resumes; without the macro, iwait never drops.
